// File: rtl/max_sched_if.sv
// Request/response bundle for max_sched: N_REQ requesters in, one max-byte response out.
// Requester i occupies req_data[i*4*BYTE_W +: 4*BYTE_W].
interface max_sched_if #(
   parameter int N_REQ  = 4,
   parameter int BYTE_W = 8
);
   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ*4*BYTE_W-1:0] req_data;
   logic [N_REQ-1:0]          req_ready;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [2:0]                rsp_id;
   logic [BYTE_W-1:0]         rsp_max;
   logic [1:0]                rsp_lane;
   logic                      busy;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_max, rsp_lane, busy
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_max, rsp_lane, busy
   );
endinterface

// File: rtl/max_sched.sv
// Round-robin scheduler in front of a shared 2-stage 4-byte max tree.
// Net tie rule: the highest-index lane holding the maximum wins.

module max_sched_max2 #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_val,
   input  logic [1:0]   a_lane,
   input  logic [W-1:0] b_val,
   input  logic [1:0]   b_lane,
   output logic [W-1:0] y_val,
   output logic [1:0]   y_lane
);
   // 'a' is always the higher-lane operand, so ties go to it
   assign y_val  = (a_val >= b_val) ? a_val  : b_val;
   assign y_lane = (a_val >= b_val) ? a_lane : b_lane;
endmodule

module max_sched #(
   parameter int N_REQ  = 4,
   parameter int BYTE_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   max_sched_if.slave  bus
);
   localparam int ID_W   = 3;
   localparam int STAGES = 2;

   logic [N_REQ-1:0][3:0][BYTE_W-1:0] words;
   logic [3:0][BYTE_W-1:0]            sel;
   logic                              advance, xfer, gnt_found;
   logic [ID_W-1:0]                   gnt_id, ptr;
   logic [STAGES:1]                   vld_pipe;

   logic [1:0][BYTE_W-1:0] pr_val, s1_val;
   logic [1:0][1:0]        pr_lane, s1_lane;
   logic [ID_W-1:0]        s1_id, rsp_id_q;
   logic [BYTE_W-1:0]      fin_val, rsp_max_q;
   logic [1:0]             fin_lane, rsp_lane_q;

   assign words   = bus.req_data;
   assign advance = !(bus.rsp_valid && !bus.rsp_ready);
   assign xfer    = gnt_found && advance;

   // First requester at or after ptr, wrapping modulo N_REQ
   always_comb begin
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_id    = '0;
      sel       = words[0];
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!gnt_found && bus.req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = ID_W'(idx);
            sel       = words[idx];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_REQ; i++)
         bus.req_ready[i] = xfer && (gnt_id == ID_W'(i));
   end

   // Stage-1 pairs: p=1 -> lanes 3/2 (e), p=0 -> lanes 1/0 (f)
   for (genvar p = 0; p < 2; p++) begin : g_pair
      max_sched_max2 #(.W(BYTE_W)) u_max2 (
         .a_val  (sel[2*p+1]),
         .a_lane (2'(2*p+1)),
         .b_val  (sel[2*p]),
         .b_lane (2'(2*p)),
         .y_val  (pr_val[p]),
         .y_lane (pr_lane[p])
      );
   end

   max_sched_max2 #(.W(BYTE_W)) u_final (
      .a_val  (s1_val[1]),
      .a_lane (s1_lane[1]),
      .b_val  (s1_val[0]),
      .b_lane (s1_lane[0]),
      .y_val  (fin_val),
      .y_lane (fin_lane)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= '0;
         vld_pipe   <= '0;
         s1_val     <= '0;
         s1_lane    <= '0;
         s1_id      <= '0;
         rsp_id_q   <= '0;
         rsp_max_q  <= '0;
         rsp_lane_q <= '0;
      end else if (advance) begin
         vld_pipe   <= {vld_pipe[STAGES-1:1], xfer};
         s1_val     <= pr_val;
         s1_lane    <= pr_lane;
         s1_id      <= gnt_id;
         rsp_id_q   <= s1_id;
         rsp_max_q  <= fin_val;
         rsp_lane_q <= fin_lane;
         if (xfer)
            ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
      end
   end

   assign bus.rsp_valid = vld_pipe[STAGES];
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_max   = rsp_max_q;
   assign bus.rsp_lane  = rsp_lane_q;
   assign bus.busy      = |vld_pipe;
endmodule

// File: tb/tb_max_sched.sv
// Bench for max_sched: directed scenarios plus randomized traffic against a
// transaction-level model (byte scan for the max, modulo arithmetic for round-robin).
module tb_max_sched;
   localparam int N  = 4;
   localparam int BW = 8;

   typedef struct {int id; int mx; int lane;} ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   max_sched_if #(.N_REQ(N), .BYTE_W(BW)) bus();
   max_sched #(.N_REQ(N), .BYTE_W(BW)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int   n_cmp = 0;
   int   n_fail = 0;
   int   m_ptr = 0;
   bit   m_s1_v = 0, m_out_v = 0;
   ent_t m_s1, m_out;
   logic [31:0] word [N];

   function automatic ent_t ref_max(int id, logic [31:0] w);
      ent_t e;
      e.id = id; e.mx = 0; e.lane = 0;
      for (int l = 0; l < 4; l++)
         if (int'(w[l*8 +: 8]) >= e.mx) begin e.mx = int'(w[l*8 +: 8]); e.lane = l; end
      return e;
   endfunction

   function automatic int exp_grant(logic [N-1:0] v);
      for (int k = 0; k < N; k++)
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r = '0;
      int g = exp_grant(bus.req_valid);
      if (!(m_out_v && !bus.rsp_ready) && g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   task automatic set_word(input int i, input logic [31:0] w);
      word[i] = w;
      bus.req_data[i*32 +: 32] = w;
   endtask

   task automatic model_reset();
      m_ptr = 0; m_s1_v = 0; m_out_v = 0;
   endtask

   // One clock edge; the model advances from the inputs sampled before it.
   task automatic tick(output int g);
      bit   adv;
      ent_t nxt;
      g   = exp_grant(bus.req_valid);
      adv = !(m_out_v && !bus.rsp_ready);
      if (!adv) g = -1;
      if (g >= 0) nxt = ref_max(g, bus.req_data[g*32 +: 32]);
      @(posedge clk);
      if (adv) begin
         m_out_v = m_s1_v; m_out = m_s1;
         m_s1_v = (g >= 0);
         if (g >= 0) begin m_s1 = nxt; m_ptr = (g + 1) % N; end
      end
      #1;
   endtask

   task automatic apply_reset();
      bus.req_valid = '0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.req_valid = '0; bus.rsp_ready = 1'b0; bus.req_data = '0;
      #1;
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%0b exp=0", bus.rsp_valid); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
      n_cmp++; if (bus.rsp_id !== 3'd0) begin n_fail++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
      n_cmp++; if (bus.rsp_max !== 8'd0) begin n_fail++; $display("FAIL reset_rsp_max got=%0h exp=0", bus.rsp_max); end
      n_cmp++; if (bus.rsp_lane !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_lane got=%0d exp=0", bus.rsp_lane); end
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int g;
      apply_reset();
      set_word(0, 32'h12345678);
      bus.req_valid = 4'b0001; bus.rsp_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
      tick(g); bus.req_valid = '0;
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_drop got=%b exp=0000", bus.req_ready); end
      n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_stage1 got v=%0b busy=%0b exp v=0 busy=1", bus.rsp_valid, bus.busy); end
      tick(g);
      @(negedge clk);
      n_cmp++; if ({bus.rsp_valid, bus.rsp_max, bus.rsp_lane, bus.rsp_id} !== {1'b1, 8'h78, 2'd0, 3'd0})
         begin n_fail++; $display("FAIL single_rsp got v=%0b max=%0h lane=%0d id=%0d exp v=1 max=78 lane=0 id=0", bus.rsp_valid, bus.rsp_max, bus.rsp_lane, bus.rsp_id); end
      tick(g);
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_drain got v=%0b busy=%0b exp 0 0", bus.rsp_valid, bus.busy); end
   endtask

   task automatic test_tie();
      int g;
      set_word(2, 32'h127F7F05);
      bus.req_valid = 4'b0100; bus.rsp_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL tie_ready0 got=%b exp=0100", bus.req_ready); end
      tick(g);
      set_word(2, 32'hAAAAAAAA);
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL tie_ready1 got=%b exp=0100", bus.req_ready); end
      tick(g); bus.req_valid = '0;
      @(negedge clk);
      n_cmp++; if ({bus.rsp_valid, bus.rsp_max, bus.rsp_lane, bus.rsp_id} !== {1'b1, 8'h7F, 2'd2, 3'd2})
         begin n_fail++; $display("FAIL tie_mid got v=%0b max=%0h lane=%0d id=%0d exp v=1 max=7f lane=2 id=2", bus.rsp_valid, bus.rsp_max, bus.rsp_lane, bus.rsp_id); end
      tick(g);
      @(negedge clk);
      n_cmp++; if ({bus.rsp_valid, bus.rsp_max, bus.rsp_lane, bus.rsp_id} !== {1'b1, 8'hAA, 2'd3, 3'd2})
         begin n_fail++; $display("FAIL tie_all got v=%0b max=%0h lane=%0d id=%0d exp v=1 max=aa lane=3 id=2", bus.rsp_valid, bus.rsp_max, bus.rsp_lane, bus.rsp_id); end
      tick(g); tick(g);
   endtask

   task automatic test_rr_fairness();
      int   g;
      ent_t e;
      apply_reset();
      for (int i = 0; i < N; i++) set_word(i, $urandom);
      bus.req_valid = 4'b1111; bus.rsp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         n_cmp++; if (bus.req_ready !== 4'(1 << (c % N))) begin n_fail++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.req_ready, 4'(1 << (c % N))); end
         if (c >= 2) begin
            e = ref_max((c - 2) % N, word[(c - 2) % N]);
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) != e.id || int'(bus.rsp_max) != e.mx || int'(bus.rsp_lane) != e.lane) begin
               n_fail++;
               $display("FAIL rr_rsp c=%0d got v=%0b id=%0d max=%0h lane=%0d exp v=1 id=%0d max=%0h lane=%0d",
                        c, bus.rsp_valid, bus.rsp_id, bus.rsp_max, bus.rsp_lane, e.id, e.mx, e.lane);
            end
         end
         tick(g);
      end
      bus.req_valid = '0;
      tick(g); tick(g);
   endtask

   task automatic test_back_to_back_backpressure();
      int           g, eid;
      logic [N-1:0] pend, er;
      ent_t         e;
      apply_reset();
      for (int i = 0; i < 3; i++) set_word(i, $urandom);
      pend = 4'b0111;
      for (int c = 0; c < 12; c++) begin
         bus.req_valid = pend;
         bus.rsp_ready = (c >= 7);
         case (c)
            0: er = 4'b0001;
            1: er = 4'b0010;
            7: er = 4'b0100;
            default: er = 4'b0000;
         endcase
         eid = (c <= 7) ? 0 : c - 7;
         @(negedge clk);
         n_cmp++; if (bus.req_ready !== er) begin n_fail++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, bus.req_ready, er); end
         n_cmp++; if (bus.rsp_valid !== (c >= 2 && c <= 9)) begin n_fail++; $display("FAIL bp_valid c=%0d got=%0b exp=%0b", c, bus.rsp_valid, (c >= 2 && c <= 9)); end
         if (c >= 2 && c <= 9) begin
            e = ref_max(eid, word[eid]);
            n_cmp++;
            if (int'(bus.rsp_id) != e.id || int'(bus.rsp_max) != e.mx || int'(bus.rsp_lane) != e.lane) begin
               n_fail++;
               $display("FAIL bp_rsp c=%0d got id=%0d max=%0h lane=%0d exp id=%0d max=%0h lane=%0d",
                        c, bus.rsp_id, bus.rsp_max, bus.rsp_lane, e.id, e.mx, e.lane);
            end
         end
         tick(g);
         pend = pend & ~er;
      end
   endtask

   task automatic test_pointer();
      int g;
      apply_reset();
      set_word(0, 32'h01020304); set_word(3, 32'hF0E0D0C0);
      bus.rsp_ready = 1'b1;
      bus.req_valid = 4'b1000;
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL ptr_first got=%b exp=1000", bus.req_ready); end
      tick(g);
      bus.req_valid = 4'b1001;
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL ptr_wrap got=%b exp=0001", bus.req_ready); end
      tick(g);
      bus.req_valid = 4'b1000;
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL ptr_after_wrap got=%b exp=1000", bus.req_ready); end
      tick(g);
      bus.req_valid = '0;
      tick(g); tick(g); tick(g);
   endtask

   task automatic test_reset_midflight();
      int g;
      apply_reset();
      set_word(0, 32'h11223344); set_word(1, 32'h55667788); set_word(3, 32'h99AABBCC);
      bus.rsp_ready = 1'b1;
      bus.req_valid = 4'b0011; tick(g);
      bus.req_valid = 4'b0010; tick(g);
      bus.req_valid = '0;
      n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got=%0b exp=1", bus.busy); end
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++; if ({bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_max, bus.rsp_lane} !== 15'd0)
         begin n_fail++; $display("FAIL mid_async got v=%0b busy=%0b id=%0d max=%0h lane=%0d exp all 0", bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_max, bus.rsp_lane); end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale c=%0d got=%0b exp=0", c, bus.rsp_valid); end
         tick(g);
      end
      bus.req_valid = 4'b1010;
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_ptr got=%b exp=0010", bus.req_ready); end
      tick(g);
      bus.req_valid = '0;
      tick(g); tick(g);
   endtask

   task automatic test_random();
      int           g;
      logic [N-1:0] pend, er;
      logic [7:0]   b;
      logic [31:0]  w;
      apply_reset();
      pend = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && cyc < 390 && ($urandom % 3) == 0) begin
               pend[i] = 1'b1;
               w = $urandom;
               if (($urandom % 2) == 0) begin
                  b = 8'($urandom);
                  for (int l = 0; l < 4; l++)
                     w[l*8 +: 8] = (($urandom % 3) == 0) ? 8'($urandom % 4) : b;
               end
               set_word(i, w);
            end
         end
         bus.req_valid = pend;
         bus.rsp_ready = (($urandom % 4) != 0);
         @(negedge clk);
         er = exp_ready();
         n_cmp++; if (bus.req_ready !== er) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, er); end
         n_cmp++; if (bus.rsp_valid !== m_out_v || bus.busy !== (m_s1_v | m_out_v))
            begin n_fail++; $display("FAIL rnd_valid cyc=%0d got v=%0b busy=%0b exp v=%0b busy=%0b", cyc, bus.rsp_valid, bus.busy, m_out_v, m_s1_v | m_out_v); end
         if (m_out_v) begin
            n_cmp++;
            if (int'(bus.rsp_id) != m_out.id || int'(bus.rsp_max) != m_out.mx || int'(bus.rsp_lane) != m_out.lane) begin
               n_fail++;
               $display("FAIL rnd_rsp cyc=%0d got id=%0d max=%0h lane=%0d exp id=%0d max=%0h lane=%0d",
                        cyc, bus.rsp_id, bus.rsp_max, bus.rsp_lane, m_out.id, m_out.mx, m_out.lane);
            end
         end
         tick(g);
         if (g >= 0) pend[g] = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_rr_fairness();
      test_back_to_back_backpressure();
      test_pointer();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule
